// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver with a one-entry valid/ready output buffer,
// a one-cycle framing-error pulse and a sticky overrun flag.
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes a 2-of-3
// majority of the synchronized line around mid-bit, taken one cycle later.
module uart_rx_deframer #(
    parameter int PRESCALER   = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RX,
    output logic [7:0] O_DAT,
    output logic       O_VALID,
    input  logic       I_READY,
    output logic       O_FRAME_ERR,
    output logic       O_OVERRUN,
    output logic       O_BUSY
);

    localparam logic [15:0] CNT_LAST   = 16'(PRESCALER - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] CNT_DECIDE = 16'(PRESCALER / 2 + 1);
`else
    localparam logic [15:0] CNT_DECIDE = 16'(PRESCALER / 2);
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_p0;
    logic [SYNC_STAGES-1:0]   fill_p0;
    logic                     rx_s;
    logic                     rx_live;
    logic                     rx_prev;
    logic                     fall;
    logic                     bit_val;
    logic                     decide;
    logic [15:0]              cnt;
    logic [2:0]               bit_idx;
    logic [7:0]               shift;

    assign rx_s    = sync_p0[SYNC_STAGES-1];
    // fill_p0 marks when rx_s carries a real line sample rather than the reset value
    assign rx_live = fill_p0[SYNC_STAGES-1];
    // rx_prev only becomes 1 once the line has really been seen high, so a line
    // that is already low when reset releases never looks like a start edge
    assign fall    = rx_live & rx_prev & ~rx_s;
    assign decide  = (cnt == CNT_DECIDE);

    // Input synchronizer chain plus a flush marker that follows it out of reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_p0 <= '1;
            fill_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], UART_RX};
            fill_p0 <= {fill_p0[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Previous genuine line level for falling-edge detection
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_prev <= 1'b0;
        end else if (rx_live) begin
            rx_prev <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1;
    logic rx_d2;

    // Two-deep history so the decision at mid+1 sees samples mid-1, mid and mid+1
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // Frame FSM, bit timing and output buffer. The prescale counter wraps every
    // bit period, so each decision lands exactly PRESCALER cycles after the
    // previous one, the same as restarting the count at the start-bit mid-point.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            O_DAT       <= '0;
            O_VALID     <= 1'b0;
            O_FRAME_ERR <= 1'b0;
            O_OVERRUN   <= 1'b0;
            O_BUSY      <= 1'b0;
        end else begin
            O_FRAME_ERR <= 1'b0;
            // Consumer takes the byte; a byte loading in this same cycle overrides
            if (O_VALID && I_READY) begin
                O_VALID <= 1'b0;
            end
            if (state != IDLE) begin
                cnt <= (cnt == CNT_LAST) ? 16'd0 : cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        state  <= START;
                        cnt    <= '0;
                        O_BUSY <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        if (bit_val) begin
                            // Line back high at mid start bit: a glitch, drop silently
                            state  <= IDLE;
                            O_BUSY <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift[bit_idx] <= bit_val;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (decide) begin
                        // Return to IDLE without waiting out the second half of the stop bit
                        state  <= IDLE;
                        O_BUSY <= 1'b0;
                        if (bit_val) begin
                            if (!O_VALID || I_READY) begin
                                O_DAT   <= shift;
                                O_VALID <= 1'b1;
                            end else begin
                                O_OVERRUN <= 1'b1;
                            end
                        end else begin
                            O_FRAME_ERR <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    O_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule
